// File: rtl/s2p_pkg.sv
// s2p_pkg: shared definitions for the serial_to_parallel deserializer.
//   cnt_w()     - width of the bit counter for a given data width
//   frame_len() - bits per frame (data bits, plus one parity bit when
//                 S2P_PARITY_EN is defined)
//   s2p_state_e - debug decode of the bit counter
package s2p_pkg;

    typedef enum logic [1:0] {
        S2P_IDLE,
        S2P_SHIFT,
        S2P_PARITY
    } s2p_state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
`ifdef S2P_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/s2p_out_buf.sv
// s2p_out_buf: one-entry valid/ready holding register for assembled words.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   load_i       - a completed, good word is offered this cycle
//   word_i       - the completed word
//   ready_i      - consumer accepts parallel_o this cycle
//   parallel_o   - buffered word (held while valid_o=1 and ready_i=0)
//   valid_o      - buffer holds a word
//   drop_o       - the offered word was lost because the buffer is full
module s2p_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_accept;

    // A new word fits if the buffer is empty or is being drained this edge.
    assign w_accept = load_i && (!r_valid || ready_i);
    assign drop_o   = load_i && r_valid && !ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_data  <= word_i;
            r_valid <= 1'b1;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign parallel_o = r_data;
    assign valid_o    = r_valid;

endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: collects qualified serial bits into WIDTH-bit words,
// MSB first, and presents each word on a one-entry valid/ready buffer.
// Optional feature macro: S2P_PARITY_EN (adds a trailing even-parity bit per
// frame and the parity_err_o port).
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   serial_i      - serial data bit, qualified by valid_i
//   valid_i       - serial_i carries a real bit (low = stall)
//   ready_i       - consumer accepts parallel_o
//   parallel_o    - assembled word
//   valid_o       - output buffer holds a word
//   busy_o        - a partial frame is in progress
//   overflow_o    - sticky: a completed word was dropped
//   parity_err_o  - one-cycle pulse on a bad frame (S2P_PARITY_EN only)
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overflow_o
`ifdef S2P_PARITY_EN
    ,
    output logic             parity_err_o
`endif
);

    localparam int              CW    = cnt_w(WIDTH);
    localparam int              FRAME = frame_len(WIDTH);
    localparam logic [CW-1:0]   LAST  = CW'(FRAME - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_overflow;
    s2p_state_e       w_state;
    logic             w_last;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] w_word;

    // The counter is the whole FSM; this decode only names its regions.
    always_comb begin
        w_state = S2P_SHIFT;
        if (r_cnt == '0) begin
            w_state = S2P_IDLE;
        end
`ifdef S2P_PARITY_EN
        else if (r_cnt == CW'(WIDTH)) begin
            w_state = S2P_PARITY;
        end
`endif
    end

    assign w_last = valid_i && (r_cnt == LAST);

`ifdef S2P_PARITY_EN
    logic w_par_ok;
    logic r_parity_err;

    // Even parity: the parity bit equals the XOR of the data bits.
    assign w_par_ok = (serial_i == ^r_sr);
    assign w_word   = r_sr;
    assign w_load   = w_last && w_par_ok;
`else
    // The final data bit completes the word in the same edge it is accepted.
    assign w_word   = {r_sr[WIDTH-2:0], serial_i};
    assign w_load   = w_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
`ifdef S2P_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (valid_i) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifdef S2P_PARITY_EN
                // The parity bit is checked, never shifted into the word.
                if (w_state != S2P_PARITY) begin
                    r_sr <= {r_sr[WIDTH-2:0], serial_i};
                end
`else
                r_sr <= {r_sr[WIDTH-2:0], serial_i};
`endif
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
`ifdef S2P_PARITY_EN
            r_parity_err <= w_last && !w_par_ok;
`endif
        end
    end

    s2p_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_load),
        .word_i     (w_word),
        .ready_i    (ready_i),
        .parallel_o (parallel_o),
        .valid_o    (valid_o),
        .drop_o     (w_drop)
    );

    assign busy_o     = (w_state != S2P_IDLE);
    assign overflow_o = r_overflow;
`ifdef S2P_PARITY_EN
    assign parity_err_o = r_parity_err;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel (WIDTH=4).
module tb_serial_to_parallel;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [3:0] parallel_o;
    logic       valid_o;
    logic       busy_o;
    logic       overflow_o;
`ifdef S2P_PARITY_EN
    logic       parity_err_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_to_parallel #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_i   (serial_i),
        .valid_i    (valid_i),
        .ready_i    (ready_i),
        .parallel_o (parallel_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
`ifdef S2P_PARITY_EN
        ,
        .parity_err_o (parity_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       v;
        logic       r;
        logic [3:0] par;
        logic       vo;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] par, input logic vo,
                             input logic busy, input logic ovf);
        check({tag, ".parallel_o"}, 32'(parallel_o), 32'(par));
        check({tag, ".valid_o"},    32'(valid_o),    32'(vo));
        check({tag, ".busy_o"},     32'(busy_o),     32'(busy));
        check({tag, ".overflow_o"}, 32'(overflow_o), 32'(ovf));
    endtask

    // Drive inputs 1 time unit after an edge, then sample 1 unit after the next.
    task automatic step(input logic s, input logic v, input logic r);
        serial_i = s;
        valid_i  = v;
        ready_i  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        serial_i = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
`ifndef S2P_PARITY_EN
        //            s     v     r     par   vo    busy  ovf
        // word 4'hB, ready held high
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0};
        // word 4'h6 with a 3-cycle stall between bits 2 and 3; B drains on bit 1
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'hB, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0};
        // word 4'h3; 6 drains on its first bit
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0};
        // word 4'hC; ready pulsed only on its completion edge
        vecs[15] = '{1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0};
        // drain, then ready with empty buffer is ignored
        vecs[19] = '{1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0};

        do_reset();
        check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].s, vecs[i].v, vecs[i].r);
            check_all($sformatf("vec%0d", i), vecs[i].par, vecs[i].vo,
                      vecs[i].busy, vecs[i].ovf);
        end

        // Overflow: ready low throughout, send A then 5.
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("ovf.wordA", 4'hA, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("ovf.bit7", 4'hA, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_all("ovf.bit8", 4'hA, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_all("ovf.hold", 4'hA, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_all("ovf.drain", 4'hA, 1'b0, 1'b0, 1'b1);

        // Reset mid-word: asynchronous assertion between edges.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("midrst.busy_before", 32'(busy_o), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_all("midrst.async", 4'h0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_all("midrst.bit3", 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_all("midrst.wordF", 4'hF, 1'b1, 1'b0, 1'b0);
`else
        do_reset();
        check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        check("reset.parity_err", 32'(parity_err_o), 32'd0);

        // 1,0,0,1 with parity 1: bad frame.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_all("par.bit4", 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_all("par.bad", 4'h0, 1'b0, 1'b0, 1'b0);
        check("par.bad.err", 32'(parity_err_o), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        check("par.err_pulse_end", 32'(parity_err_o), 32'd0);

        // 1,0,0,1 with parity 0: good frame.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("par.good", 4'h9, 1'b1, 1'b0, 1'b0);
        check("par.good.err", 32'(parity_err_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Deserializer that sits directly downstream of the 4-bit parallel-to-serial converter. It collects a stream of qualified serial bits into WIDTH-bit words, MSB first. Each completed word is presented on a one-entry valid/ready output buffer for the next stage. Lost words are flagged with a sticky overflow indication.

## Interface
- WIDTH, 4, data word width in bits; legal range ≥ 2.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- serial_i  in  1  serial data bit.
- valid_i  in  1  serial_i is a real bit this cycle; low means stall.
- ready_i  in  1  consumer accepts parallel_o this cycle.
- parallel_o  out  WIDTH  assembled word; stable while valid_o=1.
- valid_o  out  1  output buffer holds a word.
- busy_o  out  1  a partial word is in the shift register (bit count ≠ 0).
- overflow_o  out  1  sticky; set when a completed word is dropped.
- parity_err_o  out  1  one-cycle pulse on a bad frame; present only with S2P_PARITY_EN.

## Operation
- **Shift register and counter.**
  - Shift register sr[WIDTH-1:0] and bit counter cnt run 0..FRAME-1.
  - FRAME = WIDTH, or WIDTH+1 with parity.
- **States.**
  - IDLE: cnt=0.
  - SHIFT: 0<cnt<WIDTH.
  - PARITY: cnt=WIDTH, macro builds only.
  - FSM is cnt-derived; no separate state register beyond cnt.
- **Bit accept.** When valid_i=1, sr ← {sr[WIDTH-2:0], serial_i} and cnt increments.
  - The first bit received becomes parallel_o[WIDTH-1].
- **Stall.** When valid_i=0, sr and cnt hold. Gaps of any length inside a word are legal.
- **Word completion** (last frame bit accepted). cnt wraps to 0 on that edge.
  - If the buffer is empty, or is draining this cycle (valid_o=1 and ready_i=1): parallel_o ← completed word, valid_o ← 1.
  - Otherwise the word is dropped, overflow_o ← 1, and the buffer keeps its old word unchanged.
- **Drain.** When valid_o=1 and ready_i=1 with no simultaneous completion, valid_o ← 0. parallel_o holds its last value.
- **Overflow.** overflow_o clears only on rst.
- **busy_o.** busy_o = (cnt ≠ 0).

## Timing
- **Reset values.**
  - parallel_o = 0, valid_o = 0, busy_o = 0, overflow_o = 0, parity_err_o = 0.
  - sr = 0, cnt = 0.
- **Reset mid-word.** Partial bits are discarded and any buffered word is lost. The first bit after reset deassertion starts a new frame.
- **Latency.** Last bit sampled at edge N → valid_o=1 and parallel_o valid after edge N, i.e. zero added cycles.
- **Throughput.** Back-to-back words with valid_i held high are sustained: one word per FRAME cycles, provided ready_i is high at least once per word.
- **Simultaneous completion and drain.** The new word replaces the drained word in the same edge and valid_o stays 1. No overflow.
- **Handshake.** ready_i is ignored while valid_o=0. parallel_o must not change while valid_o=1 and ready_i=0.

## Configuration
- **S2P_PARITY_EN defined.**
  - Each frame carries WIDTH data bits followed by one even-parity bit.
  - In PARITY state the parity bit is checked against XOR of sr.
  - Match: word is loaded or dropped per the normal completion rules.
  - Mismatch: word is discarded, parity_err_o pulses high for one cycle after that edge, and overflow_o is unaffected.
- **S2P_PARITY_EN undefined.** FRAME = WIDTH. The PARITY state, the parity logic and the parity_err_o port are all absent.

## Structure
- **Package s2p_pkg.**
  - Counter-width function cnt_w(WIDTH) = $clog2(WIDTH+1).
  - Frame-length constant derivation.
  - State enum {S2P_IDLE, S2P_SHIFT, S2P_PARITY} used for debug decode of cnt.
- **Sub-module s2p_out_buf.** One-entry valid/ready holding register with load/drain/drop-detect logic. It outputs parallel_o, valid_o and the drop strobe feeding overflow_o.

## Test plan
- **Reset then single word.** rst high 2 cycles, release; bits 1,0,1,1 with valid_i=1 and ready_i=1.
  - parallel_o=4'hB and valid_o=1 after the 4th edge.
  - busy_o=1 during bits 2–4.
- **Stall tolerance.** Bits 0,1,1,0 with valid_i low for 3 cycles between bits 2 and 3 → parallel_o=4'h6. cnt holds during the gap.
- **Overflow.** ready_i=0 throughout; send 4'hA then 4'h5.
  - parallel_o stays 4'hA.
  - overflow_o rises after the 8th bit edge and stays set.
- **Simultaneous drain and completion.** ready_i pulsed on the completion edge of the second word (4'h3 then 4'hC).
  - valid_o stays 1 and parallel_o=4'hC.
  - overflow_o=0.
- **Reset mid-word.** After 2 bits, assert rst asynchronously between edges.
  - Outputs go to 0 immediately.
  - Next 4 bits 1,1,1,1 → 4'hF.
- **Parity (S2P_PARITY_EN).** Frame 1,0,0,1 + parity 1 → no word delivered, parity_err_o pulse. Parity 0 → parallel_o=4'h9.
